// File: rtl/issue_prf_pkg.sv
// Shared constants and types for the issue-stage physical register file.
package issue_prf_pkg;

  // Address width for a given entry count; never narrower than one bit.
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int DATA_W_DEF = 64;
  localparam int DEPTH_DEF  = 64;
  localparam int NW_DEF     = 2;
  localparam int NR_DEF     = 4;
  localparam int ADDR_W_DEF = addr_w(DEPTH_DEF);

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/issue_prf_mp_if.sv
// Bundle of write, allocate and read signals for the register file.
// There is no valid/ready handshake: wr_en and alloc_en are single-cycle
// strobes sampled on the rising clock edge, and the read side is a pure
// combinational lookup that is always available (rd_addr in, rd_data out).
interface issue_prf_mp_if import issue_prf_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NW     = NW_DEF,
  parameter int NR     = NR_DEF
) ();
  localparam int ADDR_W = addr_w(DEPTH);

  logic [NW-1:0]        wr_en;
  logic [NW*ADDR_W-1:0] wr_addr;
  logic [NW*DATA_W-1:0] wr_data;
  logic                 alloc_en;
  logic [ADDR_W-1:0]    alloc_addr;
  logic [NR*ADDR_W-1:0] rd_addr;
  logic [NR*DATA_W-1:0] rd_data;
  logic [NR-1:0]        rd_ready;
  logic [DEPTH-1:0]     ready_vec;

  modport master (
    output wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_addr,
    input  rd_data, rd_ready, ready_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_addr,
    output rd_data, rd_ready, ready_vec
  );
endinterface

// File: rtl/issue_prf_rdport.sv
// One combinational read port: stored entry, then same-cycle write
// forwarding (highest write port wins), then the hardwired zero register.
module issue_prf_rdport #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 6,
  parameter int NW      = 2,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem [DEPTH],
  input  logic [DEPTH-1:0]  rdy,
  input  logic [NW-1:0]     byp_en,
  input  logic [ADDR_W-1:0] byp_addr [NW],
  input  logic [DATA_W-1:0] byp_data [NW],
  output logic [DATA_W-1:0] data,
  output logic              ready
);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  // Priority select: later assignments override earlier ones.
  always_comb begin
    data  = '0;
    ready = 1'b0;
    if ({1'b0, addr} < DEPTH_X) begin
      data  = mem[addr];
      ready = rdy[addr];
    end
    if (BYPASS) begin
      for (int i = 0; i < NW; i++) begin
        if (byp_en[i] && (byp_addr[i] == addr)) begin
          data  = byp_data[i];
          ready = 1'b1;
        end
      end
    end
    if (ZERO_R0 && (addr == '0)) begin
      data  = '0;
      ready = 1'b1;
    end
  end
endmodule

// File: rtl/issue_prf_mp.sv
// Multi-ported physical register file with per-entry ready bits for the
// issue stage: NW write ports, one rename-allocate port, NR read ports.
module issue_prf_mp import issue_prf_pkg::*; #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int NW      = NW_DEF,
  parameter int NR      = NR_DEF,
  parameter bit BYPASS  = 1'b1,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic            clk,
  input  logic            resetn,
  issue_prf_mp_if.slave   bus
);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  rdy;

  logic [ADDR_W-1:0] wa [NW];
  logic [DATA_W-1:0] wd [NW];
  logic [NW-1:0]     wr_ok;
  logic [NW-1:0]     byp_en;
  logic              alloc_ok;

  logic [NR*DATA_W-1:0] rd_data_w;
  logic [NR-1:0]        rd_ready_w;

  // Unpack write ports and drop writes to r0 or past the last entry.
  // Forwarding is suppressed during reset so reads show the cleared file.
  always_comb begin
    for (int i = 0; i < NW; i++) begin
      wa[i]    = bus.wr_addr[i*ADDR_W +: ADDR_W];
      wd[i]    = bus.wr_data[i*DATA_W +: DATA_W];
      wr_ok[i] = bus.wr_en[i] && ({1'b0, wa[i]} < DEPTH_X) &&
                 !(ZERO_R0 && (wa[i] == '0));
    end
    byp_en   = wr_ok & {NW{resetn}};
    alloc_ok = bus.alloc_en && ({1'b0, bus.alloc_addr} < DEPTH_X) &&
               !(ZERO_R0 && (bus.alloc_addr == '0));
  end

  // Storage and ready bits: higher write ports override lower ones, and an
  // allocate on the same entry clears ready after the write has set it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= '0;
      end
      rdy <= '1;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (wr_ok[i]) begin
          mem[wa[i]] <= wd[i];
          rdy[wa[i]] <= 1'b1;
        end
      end
      if (alloc_ok) begin
        rdy[bus.alloc_addr] <= 1'b0;
      end
    end
  end

  for (genvar j = 0; j < NR; j++) begin : g_rd
    issue_prf_rdport #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .NW     (NW),
      .BYPASS (BYPASS),
      .ZERO_R0(ZERO_R0)
    ) u_rd (
      .addr    (bus.rd_addr[j*ADDR_W +: ADDR_W]),
      .mem     (mem),
      .rdy     (rdy),
      .byp_en  (byp_en),
      .byp_addr(wa),
      .byp_data(wd),
      .data    (rd_data_w[j*DATA_W +: DATA_W]),
      .ready   (rd_ready_w[j])
    );
  end

  assign bus.rd_data   = rd_data_w;
  assign bus.rd_ready  = rd_ready_w;
  assign bus.ready_vec = rdy;
endmodule

// File: doc/issue_prf_mp.md
ISSUE_PRF_MP -- requirements
Module: issue_prf_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning entry data width.
REQ-002 SHALL have parameter DEPTH, default 64, meaning number of physical registers; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter NW, default 2, meaning number of write ports.
REQ-004 SHALL have parameter NR, default 4, meaning number of read ports.
REQ-005 SHALL have parameter BYPASS, default 1, meaning same-cycle write-to-read forwarding is enabled.
REQ-006 SHALL have parameter ZERO_R0, default 1, meaning entry 0 is hardwired zero.
REQ-007 Port: clk  input  1  sole clock, rising edge.
REQ-008 Port: resetn  input  1  reset, asynchronous, active-low.
REQ-009 Port: wr_en  input  NW  per-port write enable.
REQ-010 Port: wr_addr  input  NW*ADDR_W  write addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-011 Port: wr_data  input  NW*DATA_W  write data, packed as wr_addr.
REQ-012 Port: alloc_en  input  1  rename allocation strobe; clears ready bit of alloc_addr.
REQ-013 Port: alloc_addr  input  ADDR_W  register being allocated.
REQ-014 Port: rd_addr  input  NR*ADDR_W  read addresses, packed.
REQ-015 Port: rd_data  output  NR*DATA_W  read data, packed.
REQ-016 Port: rd_ready  output  NR  ready bit of each addressed entry.
REQ-017 Port: ready_vec  output  DEPTH  registered ready bit of every entry.

Function
REQ-018 Storage and ready bits SHALL update on the rising clk edge; reads SHALL be combinational (zero-cycle latency).
REQ-019 A write with wr_en[i]=1 SHALL store wr_data[i] and set ready bit of wr_addr[i] at the edge.
REQ-020 Two or more write ports to the same address in one cycle SHALL resolve to the highest-index port's data.
REQ-021 alloc_en=1 SHALL clear ready of alloc_addr at the edge; alloc and write to the same address in one cycle: data written, ready cleared (alloc wins).
REQ-022 With BYPASS=1, rd_data[j] SHALL return matching same-cycle wr_data (highest-index matching port) and rd_ready[j]=1; with BYPASS=0 reads return stored values only.
REQ-023 With ZERO_R0=1, writes/alloc to address 0 SHALL be ignored, rd_data for address 0 SHALL be 0, rd_ready 1, ready_vec[0]=1, bypass SHALL not apply to address 0.
REQ-024 Addresses >= DEPTH (non-power-of-2 DEPTH) SHALL be ignored on write and read as 0, ready 0.
REQ-025 ready_vec SHALL reflect registered state only (no bypass).
REQ-026 All read ports SHALL be independent; any number may address the same entry.

Reset
REQ-027 resetn=0 SHALL asynchronously clear all data to 0 and set all ready bits to 1; outputs follow combinationally (rd_data=0, rd_ready=1, ready_vec all 1).
REQ-028 Writes and allocs presented while resetn=0 SHALL have no effect; first effective edge is the first rising clk after resetn deasserts.

Structure
REQ-029 Package issue_prf_pkg SHALL hold default DATA_W, DEPTH, NW, NR constants and the address/data typedefs.
REQ-030 One sub-module issue_prf_rdport SHALL implement a single read port (storage select, bypass priority, zero-reg); instantiated NR times by generate.

Verification
REQ-031 Reset then read all 64 entries on 4 ports -> rd_data=0, rd_ready=1, ready_vec=all ones.
REQ-032 alloc r5; next cycle write r5=0xDEAD_BEEF on port 0 while port 2 reads r5 -> same cycle rd_data=0xDEADBEEF, rd_ready=1 (bypass); ready_vec[5] 0 before edge, 1 after.
REQ-033 Ports 0 and 1 both write r9 (0x11, 0x22) same cycle -> next cycle r9 reads 0x22.
REQ-034 alloc r7 and write r7=0x55 same cycle -> next cycle rd_data=0x55, rd_ready=0.
REQ-035 Write r0=0xFFFF and alloc r0 -> r0 reads 0, ready 1, ready_vec[0]=1.
REQ-036 Assert resetn low mid-burst of writes to r3 -> r3 reads 0 immediately, ready 1; writes during reset lost.
